// File: rtl/arm_step_conditioner.sv
// Step/dir/enable conditioner between the arm axis peripheral and the driver.
// Enforces dir setup, pulse widths and enable settling; tracks position.
module arm_step_conditioner #(
   parameter int DIR_SETUP  = 12,
   parameter int PULSE_HIGH = 24,
   parameter int PULSE_LOW  = 24,
   parameter int EN_SETUP   = 60
) (
   input  logic        clk_12MHz,
   input  logic        reset,
   input  logic        step_in,
   input  logic        dir_in,
   input  logic        en_in,
   input  logic        fault,
   input  logic        pos_clear,
   input  logic        clear_flags,
   output logic        step_out,
   output logic        dir_out,
   output logic        en_out,
   output logic [31:0] position,
   output logic        busy,
   output logic        overrun,
   output logic        dropped
);

   typedef enum logic [1:0] {
      IDLE,
      DIR_WAIT,
      PULSE_HI,
      PULSE_LO
   } state_t;

   localparam int M1 = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
   localparam int MX = (M1 > DIR_SETUP) ? M1 : DIR_SETUP;
   localparam int CW = $clog2(MX + 1);
   localparam int EW = $clog2(EN_SETUP + 1);

   localparam logic [CW-1:0] DS_END = CW'(DIR_SETUP - 1);
   localparam logic [CW-1:0] PH_END = CW'(PULSE_HIGH - 1);
   localparam logic [CW-1:0] PL_END = CW'(PULSE_LOW - 1);
   localparam logic [EW-1:0] EN_MAX = EW'(EN_SETUP);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [EW-1:0] en_cnt;
   logic          step_q;
   logic          pend_v;
   logic          pend_dir;

   logic req;
   logic ok;
   logic en_ready;
   logic take;
   logic store;
   logic ovr_req;
   logic drop_req;
   logic lo_done;
   logic launch;
   logic ldir;

   assign en_ready = en_out && (en_cnt == EN_MAX);
   assign req      = step_in && !step_q;
   assign ok       = !fault && en_ready;
   assign take     = req && ok && (state == IDLE) && !pend_v;
   assign store    = req && ok && !take && !pend_v;
   assign ovr_req  = req && ok && pend_v;
   assign drop_req = req && !ok;
   assign lo_done  = (state == PULSE_LO) && (cnt == PL_END);
   assign busy     = (state != IDLE) || pend_v;

   // Previous step_in sample for rising-edge detection.
   always_ff @(posedge clk_12MHz) begin
      if (!reset) step_q <= 1'b0;
      else        step_q <= step_in;
   end

   // Enable follows en_in; settle counter saturates at EN_SETUP.
   always_ff @(posedge clk_12MHz) begin
      if (!reset) begin
         en_out <= 1'b0;
         en_cnt <= '0;
      end else begin
         en_out <= en_in;
         if (!en_out)               en_cnt <= '0;
         else if (en_cnt != EN_MAX) en_cnt <= en_cnt + EW'(1);
      end
   end

   // Pick the step that starts on this edge: a fresh request from
   // IDLE, or at pulse-low exit the pending one (or a same-cycle one).
   always_comb begin
      launch = 1'b0;
      ldir   = dir_in;
      if (state == IDLE) begin
         launch = take;
      end else if (lo_done) begin
         if (pend_v) begin
            launch = ok;
            ldir   = pend_dir;
         end else begin
            launch = store;
         end
      end
   end

   // Pulse sequencer, pending slot, sticky flags and position count.
   always_ff @(posedge clk_12MHz) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         step_out <= 1'b0;
         dir_out  <= 1'b0;
         position <= '0;
         pend_v   <= 1'b0;
         pend_dir <= 1'b0;
         overrun  <= 1'b0;
         dropped  <= 1'b0;
      end else begin
         if (clear_flags) begin
            overrun <= 1'b0;
            dropped <= 1'b0;
         end
         if (drop_req) dropped <= 1'b1;
         if (ovr_req)  overrun <= 1'b1;
         if (store) begin
            pend_v   <= 1'b1;
            pend_dir <= dir_in;
         end
         if (launch) begin
            cnt <= '0;
            if (lo_done) pend_v <= 1'b0;
            if (ldir == dir_out) begin
               step_out <= 1'b1;
               state    <= PULSE_HI;
               position <= ldir ? position + 32'd1
                                : position - 32'd1;
            end else begin
               dir_out <= ldir;
               state   <= DIR_WAIT;
            end
         end else begin
            unique case (state)
               IDLE: cnt <= '0;
               DIR_WAIT: begin
                  if (cnt == DS_END) begin
                     cnt      <= '0;
                     step_out <= 1'b1;
                     state    <= PULSE_HI;
                     position <= dir_out ? position + 32'd1
                                         : position - 32'd1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               PULSE_HI: begin
                  if (cnt == PH_END) begin
                     cnt      <= '0;
                     step_out <= 1'b0;
                     state    <= PULSE_LO;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               PULSE_LO: begin
                  if (lo_done) begin
                     cnt   <= '0;
                     state <= IDLE;
                     if (pend_v) begin
                        pend_v  <= 1'b0;
                        dropped <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
         if (pos_clear) position <= '0;
      end
   end

endmodule

// File: tb/tb_arm_step_conditioner.sv
// Bench for arm_step_conditioner: directed steps, expected pulses
// queued by the stimulus and checked by an independent pulse monitor.
module tb_arm_step_conditioner;

   logic        clk_12MHz;
   logic        reset;
   logic        step_in;
   logic        dir_in;
   logic        en_in;
   logic        fault;
   logic        pos_clear;
   logic        clear_flags;
   logic        step_out;
   logic        dir_out;
   logic        en_out;
   logic [31:0] position;
   logic        busy;
   logic        overrun;
   logic        dropped;

   arm_step_conditioner dut (
      .clk_12MHz  (clk_12MHz),
      .reset      (reset),
      .step_in    (step_in),
      .dir_in     (dir_in),
      .en_in      (en_in),
      .fault      (fault),
      .pos_clear  (pos_clear),
      .clear_flags(clear_flags),
      .step_out   (step_out),
      .dir_out    (dir_out),
      .en_out     (en_out),
      .position   (position),
      .busy       (busy),
      .overrun    (overrun),
      .dropped    (dropped)
   );

   typedef struct {
      logic        d;
      logic [31:0] pos;
      int          lat;
      int          gap;
      int          req;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [31:0] exp_pos = 32'd0;

   initial clk_12MHz = 1'b0;
   always #5 clk_12MHz = ~clk_12MHz;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_12MHz);
   endtask

   task automatic step(input logic d, input bit pulse,
                       input int lat, input int gap);
      exp_t e;
      dir_in  = d;
      step_in = 1'b1;
      if (pulse) begin
         exp_pos = d ? exp_pos + 32'd1 : exp_pos - 32'd1;
         e.d   = d;
         e.pos = exp_pos;
         e.lat = lat;
         e.gap = gap;
         e.req = cyc + 1;
         q.push_back(e);
      end
      tick(1);
      step_in = 1'b0;
   endtask

   task automatic clr;
      clear_flags = 1'b1;
      tick(1);
      clear_flags = 1'b0;
   endtask

   // Pulse monitor: checks each step_out rise against the queue,
   // plus pulse width and direction setup time.
   initial begin
      exp_t e;
      logic so_p = 1'b0;
      logic dir_p = 1'b0;
      int   hw = 0;
      int   dst = 0;
      int   last_rise = 0;
      forever begin
         @(posedge clk_12MHz);
         cyc++;
         #1;
         if (dir_out !== dir_p) dst = 0;
         else                   dst++;
         if (step_out && !so_p) begin
            n_cmp++;
            if (dst < 12) begin
               n_bad++;
               $display("FAIL dir_setup: got %0d cycles, required >= 12",
                        dst);
            end
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_pulse: rise at cycle %0d, required none",
                        cyc);
            end else begin
               e = q.pop_front();
               chk("pulse_dir", dir_out, e.d);
               chk("pulse_pos", position, e.pos);
               if (e.lat >= 0) chk("pulse_latency", cyc - e.req, e.lat);
               if (e.gap > 0)  chk("pulse_gap", cyc - last_rise, e.gap);
            end
            last_rise = cyc;
            hw = 1;
         end else if (step_out) begin
            hw++;
         end else if (so_p && reset) begin
            chk("pulse_width", hw, 24);
         end
         so_p  = step_out;
         dir_p = dir_out;
      end
   end

   initial begin
      reset = 1'b0;
      step_in = 1'b0;
      dir_in = 1'b0;
      en_in = 1'b0;
      fault = 1'b0;
      pos_clear = 1'b0;
      clear_flags = 1'b0;
      tick(3);
      chk("rst_step_out", step_out, 0);
      chk("rst_dir_out", dir_out, 0);
      chk("rst_en_out", en_out, 0);
      chk("rst_position", position, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_dropped", dropped, 0);
      reset = 1'b1;

      // settle enable, then a negative step with no dir change
      en_in = 1'b1;
      tick(65);
      chk("en_out_high", en_out, 1);
      step(1'b0, 1, 0, 0);
      tick(47);
      chk("busy_in_low_phase", busy, 1);
      tick(1);
      chk("busy_after_low", busy, 0);
      chk("pos_wrap_neg", position, 32'hFFFF_FFFF);

      // direction change: setup wait before the pulse
      step(1'b1, 1, 12, 0);
      chk("dir_out_next", dir_out, 1);
      chk("step_out_in_setup", step_out, 0);
      tick(70);

      // same dir again, immediate
      step(1'b1, 1, 0, 0);
      tick(60);

      // three edges 5 apart: one issued, one pending, one overrun
      step(1'b1, 1, 0, 0);
      tick(4);
      step(1'b1, 1, -1, 48);
      tick(4);
      step(1'b1, 0, 0, 0);
      tick(100);
      chk("overrun_set", overrun, 1);
      chk("dropped_clear", dropped, 0);
      chk("pos_after_burst", position, exp_pos);
      clr();
      chk("overrun_cleared", overrun, 0);

      // enable settling: early step dropped, later step accepted
      en_in = 1'b0;
      tick(3);
      en_in = 1'b1;
      tick(29);
      step(1'b1, 0, 0, 0);
      chk("dropped_early", dropped, 1);
      chk("busy_early", busy, 0);
      clr();
      chk("dropped_cleared", dropped, 0);
      tick(39);
      step(1'b1, 1, 0, 0);
      tick(60);

      // fault during pulse with a step pending
      step(1'b1, 1, 0, 0);
      tick(3);
      step(1'b1, 0, 0, 0);
      fault = 1'b1;
      tick(60);
      fault = 1'b0;
      chk("fault_dropped", dropped, 1);
      chk("fault_overrun", overrun, 0);
      chk("fault_pos", position, exp_pos);
      chk("fault_busy", busy, 0);
      clr();

      // enable falling mid-pulse with a step pending
      step(1'b1, 1, 0, 0);
      tick(3);
      step(1'b1, 0, 0, 0);
      en_in = 1'b0;
      tick(2);
      chk("en_out_low", en_out, 0);
      tick(58);
      chk("en_fall_dropped", dropped, 1);
      chk("en_fall_pos", position, exp_pos);
      en_in = 1'b1;
      clr();
      tick(65);

      // pos_clear on the same edge as a rise
      begin
         exp_t e;
         dir_in    = 1'b1;
         step_in   = 1'b1;
         pos_clear = 1'b1;
         exp_pos   = 32'd0;
         e.d   = 1'b1;
         e.pos = 32'd0;
         e.lat = 0;
         e.gap = 0;
         e.req = cyc + 1;
         q.push_back(e);
         tick(1);
         step_in   = 1'b0;
         pos_clear = 1'b0;
      end
      tick(60);
      chk("pos_clear_hold", position, 0);

      // signed wrap at the positive limit
      force dut.position = 32'h7FFF_FFFF;
      tick(1);
      release dut.position;
      exp_pos = 32'h7FFF_FFFF;
      tick(1);
      chk("pos_preload", position, 32'h7FFF_FFFF);
      step(1'b1, 1, 0, 0);
      tick(60);
      chk("pos_wrap_pos", position, 32'h8000_0000);

      // reset in the middle of a pulse
      step(1'b1, 1, 0, 0);
      tick(5);
      chk("mid_pulse_high", step_out, 1);
      reset = 1'b0;
      tick(1);
      chk("rst2_step_out", step_out, 0);
      chk("rst2_dir_out", dir_out, 0);
      chk("rst2_en_out", en_out, 0);
      chk("rst2_position", position, 0);
      chk("rst2_busy", busy, 0);
      chk("rst2_flags", {overrun, dropped}, 0);
      reset = 1'b1;
      tick(5);
      chk("pulses_outstanding", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/arm_step_conditioner.md
Name: arm_step_conditioner

Overview:
- Sits directly downstream of the arm axis peripheral, between its step/dir/enable outputs and the external stepper driver pins.
- Enforces driver timing: direction setup before each step edge, minimum step high and low widths, and enable settling time.
- Buffers one pending step request.
- Keeps a signed 32-bit absolute position count of the pulses actually issued, so the bus can read true axis position.

Parameters:
- DIR_SETUP, 12, clock cycles dir_out must be stable before a step_out rising edge (1 us at 12 MHz).
- PULSE_HIGH, 24, exact step_out high width in cycles.
- PULSE_LOW, 24, minimum step_out low time after each pulse, in cycles.
- EN_SETUP, 60, consecutive cycles en_out must be high before steps are accepted.

Ports:
- clk_12MHz  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- step_in  input  1  step request; a rising edge requests one step (polarity already normalized).
- dir_in  input  1  requested direction; 1 = positive, 0 = negative; sampled on the step_in rising edge.
- en_in  input  1  driver enable request.
- fault  input  1  driver fault; while high, new step requests are dropped.
- pos_clear  input  1  when high for one cycle, position is set to 0.
- clear_flags  input  1  when high for one cycle, overrun and dropped are cleared.
- step_out  output  1  conditioned step pulse to the driver.
- dir_out  output  1  conditioned direction to the driver.
- en_out  output  1  driver enable.
- position  output  32  signed step count (two's complement).
- busy  output  1  high whenever the FSM is not IDLE or a step is pending.
- overrun  output  1  sticky; a request was lost because the pending buffer was full.
- dropped  output  1  sticky; a request was rejected because of fault or enable not settled.

Behaviour:
- Reset: while reset is low at a clock edge, all state clears on that edge.
  - step_out=0, dir_out=0, en_out=0, position=0, busy=0, overrun=0, dropped=0.
  - FSM goes to IDLE, the pending buffer is empty, and the enable counter is 0.
  - Reset mid-pulse forces step_out low on that edge; the step already counted stays lost (position=0).
- Edge detection: step_in is registered. A request exists in cycle N when step_in=1 and the previous sample was 0. {dir_in} is captured with the request.
- Enable:
  - en_out <= en_in every cycle, one cycle of latency.
  - en_ready is set once en_out has been high for EN_SETUP consecutive cycles; the counter saturates.
  - en_out=0 clears the counter and en_ready immediately.
- Request acceptance, checked in this order:
  - If fault=1 or en_ready=0: the request is discarded and dropped <= 1.
  - Else if the FSM is IDLE and no step is pending: the request is taken directly.
  - Else if no step is pending: the request is stored in the pending slot (dir stored with it).
  - Else: the request is discarded and overrun <= 1.
- FSM states: IDLE, DIR_WAIT, PULSE_HI, PULSE_LO.
  - IDLE, request taken with dir == dir_out: on the next edge step_out <= 1 and the FSM enters PULSE_HI.
  - IDLE, request taken with dir != dir_out: on the next edge dir_out <= dir and the FSM enters DIR_WAIT.
  - DIR_WAIT: lasts DIR_SETUP cycles, then step_out <= 1 and the FSM enters PULSE_HI.
  - PULSE_HI: step_out is held high for exactly PULSE_HIGH cycles, then step_out <= 0 and the FSM enters PULSE_LO.
  - PULSE_LO: lasts PULSE_LOW cycles. On exit, if a step is pending it is consumed as if just taken in IDLE (same dir-compare rule, no idle cycle); otherwise the FSM returns to IDLE.
- dir_out changes only on the IDLE→DIR_WAIT (or PULSE_LO→DIR_WAIT) transition, never while step_out=1 or during PULSE_LO.
- Position arithmetic:
  - On the edge where step_out rises, position += 1 if dir_out=1, else position -= 1.
  - 32-bit two's complement; wraps silently (0x7FFFFFFF + 1 = 0x80000000).
- pos_clear:
  - pos_clear has priority over a same-cycle increment; the result is 0.
  - A pulse already in flight is not re-counted.
- clear_flags: clears both sticky flags. If a set condition occurs in the same cycle, the flag is set (set wins).
- fault rising mid-pulse: the current pulse completes normally. A pending step is consumed only if fault=0 at PULSE_LO exit; otherwise it is discarded and dropped <= 1.
- en_in falling mid-pulse:
  - en_out drops next cycle.
  - The current pulse completes its timing; the pending step is discarded and dropped <= 1.

Test Plan:
- en_in=1 held 60 cycles; single step_in edge, dir_in=1 → step_out high exactly 24 cycles starting 1 cycle after the edge; position=1; busy low 24 cycles after step_out falls.
- dir_out=1; step_in edge with dir_in=0 → dir_out falls 1 cycle after the edge; step_out rises 12 cycles later; position goes from 1 to 0.
- Three step_in edges 5 cycles apart, same dir → first pulse issued, second pending, third sets overrun=1. Exactly 2 pulses appear, rising edges 48 cycles apart; position += 2.
- Step edge 30 cycles after en_in rises → no pulse, dropped=1. clear_flags pulse → dropped=0. Step edge at cycle 70 → pulse issued.
- fault=1 during PULSE_HI with a step pending → current pulse is a full 24 cycles; pending step discarded; dropped=1; position +1 only.
- position preloaded by 0x7FFFFFFF steps (or forced), dir=1 step → position=0x80000000. pos_clear in the same cycle as a step_out rise → position=0. Reset low mid-PULSE_HI → step_out=0 and all outputs at reset values next edge.
